// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing configuration bank:
// built-in mode table, register map offsets and controller states.
package vga_timing_pkg;

  localparam int PRESET_ID_WIDTH = 2;
  localparam logic [PRESET_ID_WIDTH-1:0] PRESET_CUSTOM = 2'd3;

  // Word offsets from the window base; offsets 10..15 are reserved.
  localparam int         WINDOW_WORDS   = 16;
  localparam logic [3:0] OFF_CTRL       = 4'd0;
  localparam logic [3:0] OFF_H_MAX      = 4'd1;
  localparam logic [3:0] OFF_V_MAX      = 4'd2;
  localparam logic [3:0] OFF_H_SYNC     = 4'd3;
  localparam logic [3:0] OFF_V_SYNC     = 4'd4;
  localparam logic [3:0] OFF_H_LEFT     = 4'd5;
  localparam logic [3:0] OFF_H_RIGHT    = 4'd6;
  localparam logic [3:0] OFF_V_LEFT     = 4'd7;
  localparam logic [3:0] OFF_V_RIGHT    = 4'd8;
  localparam logic [3:0] OFF_COMMIT_NOW = 4'd9;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_PENDING, ST_APPLY} state_t;

  typedef struct packed {
    logic [15:0] h_count_max, h_sync, h_left, h_right;
    logic [15:0] v_count_max, v_sync, v_left, v_right;
  } preset_t;

  localparam preset_t PRESET_640X480 = '{
    h_count_max: 16'd799,  h_sync: 16'd96,  h_left: 16'd48,  h_right: 16'd16,
    v_count_max: 16'd524,  v_sync: 16'd2,   v_left: 16'd33,  v_right: 16'd10};
  localparam preset_t PRESET_800X600 = '{
    h_count_max: 16'd1055, h_sync: 16'd128, h_left: 16'd88,  h_right: 16'd40,
    v_count_max: 16'd627,  v_sync: 16'd4,   v_left: 16'd23,  v_right: 16'd1};
  localparam preset_t PRESET_1024X768 = '{
    h_count_max: 16'd1343, h_sync: 16'd136, h_left: 16'd160, h_right: 16'd24,
    v_count_max: 16'd805,  v_sync: 16'd6,   v_left: 16'd29,  v_right: 16'd3};

  function automatic preset_t preset_lookup(input logic [PRESET_ID_WIDTH-1:0] id);
    case (id)
      2'd1:    return PRESET_800X600;
      2'd2:    return PRESET_1024X768;
      default: return PRESET_640X480;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_check.sv
// Sanity check of a candidate timing set: each total must exceed its
// sync + back porch + front porch, leaving a non-empty visible region.
module vga_timing_check #(
  parameter int REZ_MAX_WIDTH = 11,
  parameter int PULSE_WIDTH   = 8,
  parameter int MARGIN_WIDTH  = 8
) (
  input  logic [REZ_MAX_WIDTH-1:0] h_count_max,
  input  logic [REZ_MAX_WIDTH-1:0] v_count_max,
  input  logic [PULSE_WIDTH-1:0]   h_sync,
  input  logic [PULSE_WIDTH-1:0]   v_sync,
  input  logic [MARGIN_WIDTH-1:0]  h_left,
  input  logic [MARGIN_WIDTH-1:0]  h_right,
  input  logic [MARGIN_WIDTH-1:0]  v_left,
  input  logic [MARGIN_WIDTH-1:0]  v_right,
  output logic                     pass
);

  localparam int SUM_WIDTH = REZ_MAX_WIDTH + 2;

  logic [SUM_WIDTH-1:0] h_sum;
  logic [SUM_WIDTH-1:0] v_sum;

  // NOTE: every output of this block is assigned on every pass, so no latch is inferred.
  always_comb begin
    h_sum = SUM_WIDTH'(h_sync) + SUM_WIDTH'(h_left) + SUM_WIDTH'(h_right);
    v_sum = SUM_WIDTH'(v_sync) + SUM_WIDTH'(v_left) + SUM_WIDTH'(v_right);
    pass  = (SUM_WIDTH'(h_count_max) > h_sum) && (SUM_WIDTH'(v_count_max) > v_sum);
  end

endmodule

// File: rtl/vga_timing_cfg_bank.sv
// Shadow/active VGA timing register bank. Commits are validated, then held
// until a frame boundary (or the watchdog) so a mode switch never tears a frame.
module vga_timing_cfg_bank
  import vga_timing_pkg::*;
#(
  parameter int                      CONFIG_WIDTH  = 16,
  parameter int                      REZ_MAX_WIDTH = 11,
  parameter int                      PULSE_WIDTH   = 8,
  parameter int                      MARGIN_WIDTH  = 8,
  parameter logic [CONFIG_WIDTH-1:0] ADDR_BASE     = 16'h0010,
  parameter int                      TIMEOUT_WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Valid,
  input  logic [CONFIG_WIDTH-1:0]    Addr,
  input  logic [CONFIG_WIDTH-1:0]    Data,
  output logic                       Ready,
  input  logic                       Frame_end,
  output logic                       Load_config,
  output logic                       Pending,
  output logic                       Cfg_error,
  output logic [PRESET_ID_WIDTH-1:0] Preset_id,
  output logic [REZ_MAX_WIDTH-1:0]   H_count_max,
  output logic [REZ_MAX_WIDTH-1:0]   V_count_max,
  output logic [PULSE_WIDTH-1:0]     H_sync_pulse,
  output logic [PULSE_WIDTH-1:0]     V_sync_pulse,
  output logic [MARGIN_WIDTH-1:0]    H_left_margin,
  output logic [MARGIN_WIDTH-1:0]    H_right_margin,
  output logic [MARGIN_WIDTH-1:0]    V_left_margin,
  output logic [MARGIN_WIDTH-1:0]    V_right_margin
);

  typedef struct packed {
    logic [REZ_MAX_WIDTH-1:0] h_count_max, v_count_max;
    logic [PULSE_WIDTH-1:0]   h_sync, v_sync;
    logic [MARGIN_WIDTH-1:0]  h_left, h_right, v_left, v_right;
  } timing_t;

  function automatic timing_t to_timing(input preset_t p);
    timing_t t;
    t.h_count_max = REZ_MAX_WIDTH'(p.h_count_max);
    t.v_count_max = REZ_MAX_WIDTH'(p.v_count_max);
    t.h_sync      = PULSE_WIDTH'(p.h_sync);
    t.v_sync      = PULSE_WIDTH'(p.v_sync);
    t.h_left      = MARGIN_WIDTH'(p.h_left);
    t.h_right     = MARGIN_WIDTH'(p.h_right);
    t.v_left      = MARGIN_WIDTH'(p.v_left);
    t.v_right     = MARGIN_WIDTH'(p.v_right);
    return t;
  endfunction

  // A zero-width watchdog is kept as one idle bit so the logic stays uniform.
  localparam int                  WD_WIDTH = (TIMEOUT_WIDTH > 0) ? TIMEOUT_WIDTH : 1;
  localparam logic [WD_WIDTH-1:0] WD_ONES  = '1;
  localparam logic [WD_WIDTH-1:0] WD_LAST  = WD_ONES - WD_WIDTH'(1);

  state_t                      state;
  timing_t                     shadow;
  timing_t                     active;
  logic [PRESET_ID_WIDTH-1:0]  commit_id;
  logic                        immediate;
  logic [WD_WIDTH-1:0]         watchdog;
  logic [CONFIG_WIDTH-1:0]     offset;
  logic                        in_window;
  logic                        timeout_hit;
  logic                        check_pass;
  logic                        unused_data;

  assign offset      = Addr - ADDR_BASE;
  assign in_window   = offset < CONFIG_WIDTH'(WINDOW_WORDS);
  assign timeout_hit = (TIMEOUT_WIDTH > 0) && (watchdog == WD_LAST);
  assign unused_data = ^Data;

  vga_timing_check #(
    .REZ_MAX_WIDTH (REZ_MAX_WIDTH),
    .PULSE_WIDTH   (PULSE_WIDTH),
    .MARGIN_WIDTH  (MARGIN_WIDTH)
  ) u_check (
    .h_count_max (shadow.h_count_max),
    .v_count_max (shadow.v_count_max),
    .h_sync      (shadow.h_sync),
    .v_sync      (shadow.v_sync),
    .h_left      (shadow.h_left),
    .h_right     (shadow.h_right),
    .v_left      (shadow.v_left),
    .v_right     (shadow.v_right),
    .pass        (check_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: both timing sets are architectural state with defined power-up modes, so they are reset.
      state       <= ST_IDLE;
      shadow      <= to_timing(PRESET_640X480);
      active      <= to_timing(PRESET_640X480);
      Preset_id   <= '0;
      commit_id   <= '0;
      immediate   <= 1'b0;
      watchdog    <= '0;
      Ready       <= 1'b1;
      Pending     <= 1'b0;
      Load_config <= 1'b1;
      Cfg_error   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here; a later assignment in this block overrides it.
      Load_config <= 1'b0;
      Cfg_error   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Valid && Ready && in_window) begin
            case (offset[3:0])
              OFF_CTRL: begin
                if (Data[1:0] != PRESET_CUSTOM) shadow <= to_timing(preset_lookup(Data[1:0]));
                commit_id <= Data[1:0];
                immediate <= 1'b0;
                state     <= ST_CHECK;
                Ready     <= 1'b0;
              end
              OFF_H_MAX:   shadow.h_count_max <= Data[REZ_MAX_WIDTH-1:0];
              OFF_V_MAX:   shadow.v_count_max <= Data[REZ_MAX_WIDTH-1:0];
              OFF_H_SYNC:  shadow.h_sync      <= Data[PULSE_WIDTH-1:0];
              OFF_V_SYNC:  shadow.v_sync      <= Data[PULSE_WIDTH-1:0];
              OFF_H_LEFT:  shadow.h_left      <= Data[MARGIN_WIDTH-1:0];
              OFF_H_RIGHT: shadow.h_right     <= Data[MARGIN_WIDTH-1:0];
              OFF_V_LEFT:  shadow.v_left      <= Data[MARGIN_WIDTH-1:0];
              OFF_V_RIGHT: shadow.v_right     <= Data[MARGIN_WIDTH-1:0];
              OFF_COMMIT_NOW: begin
                commit_id <= PRESET_CUSTOM;
                immediate <= 1'b1;
                state     <= ST_CHECK;
                Ready     <= 1'b0;
              end
              default: Cfg_error <= 1'b1;
            endcase
          end
        end
        ST_CHECK: begin
          if (!check_pass) begin
            Cfg_error <= 1'b1;
            Ready     <= 1'b1;
            state     <= ST_IDLE;
          end else if (immediate) begin
            active      <= shadow;
            Preset_id   <= commit_id;
            Load_config <= 1'b1;
            state       <= ST_APPLY;
          end else begin
            Pending  <= 1'b1;
            watchdog <= '0;
            state    <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (TIMEOUT_WIDTH > 0) watchdog <= watchdog + WD_WIDTH'(1);
          // The copy lands on this edge so new values and Load_config appear together in APPLY.
          if (Frame_end || timeout_hit) begin
            active      <= shadow;
            Preset_id   <= commit_id;
            Load_config <= 1'b1;
            Pending     <= 1'b0;
            state       <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          watchdog <= '0;
          Ready    <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          Ready   <= 1'b1;
          Pending <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign H_count_max    = active.h_count_max;
  assign V_count_max    = active.v_count_max;
  assign H_sync_pulse   = active.h_sync;
  assign V_sync_pulse   = active.v_sync;
  assign H_left_margin  = active.h_left;
  assign H_right_margin = active.h_right;
  assign V_left_margin  = active.v_left;
  assign V_right_margin = active.v_right;

endmodule

// File: tb/tb_vga_timing_cfg_bank.sv
// Directed bench for vga_timing_cfg_bank: a default instance plus one with a
// 4-bit watchdog so the timeout path is reachable in a short run.
module tb_vga_timing_cfg_bank;

  // Active set packed as {H max, V max, H sync, V sync, HL, HR, VL, VR}.
  localparam logic [69:0] P0   = {11'd799,  11'd524, 8'd96,  8'd2, 8'd48,  8'd16, 8'd33, 8'd10};
  localparam logic [69:0] P1   = {11'd1055, 11'd627, 8'd128, 8'd4, 8'd88,  8'd40, 8'd23, 8'd1};
  localparam logic [69:0] P2   = {11'd1343, 11'd805, 8'd136, 8'd6, 8'd160, 8'd24, 8'd29, 8'd3};
  localparam logic [69:0] CUST = {11'd999,  11'd599, 8'd100, 8'd5, 8'd50,  8'd50, 8'd20, 8'd5};
  localparam logic [69:0] C201 = {11'd201,  11'd599, 8'd100, 8'd5, 8'd50,  8'd50, 8'd20, 8'd5};

  logic        clk;
  logic        rst_n;
  logic        Valid, wd_valid;
  logic [15:0] Addr, Data;
  logic        Frame_end;

  logic        Ready, Load_config, Pending, Cfg_error;
  logic [1:0]  Preset_id;
  logic [10:0] H_count_max, V_count_max;
  logic [7:0]  H_sync_pulse, V_sync_pulse, H_left_margin, H_right_margin, V_left_margin, V_right_margin;

  logic        w_ready, w_load, w_pending, w_error;
  logic [1:0]  w_preset;
  logic [10:0] w_hmax, w_vmax;
  logic [7:0]  w_hsync, w_vsync, w_hl, w_hr, w_vl, w_vr;

  logic [69:0] act, w_act;
  assign act   = {H_count_max, V_count_max, H_sync_pulse, V_sync_pulse,
                  H_left_margin, H_right_margin, V_left_margin, V_right_margin};
  assign w_act = {w_hmax, w_vmax, w_hsync, w_vsync, w_hl, w_hr, w_vl, w_vr};

  int vectors;
  int miscompares;

  vga_timing_cfg_bank dut (
    .clk(clk), .rst_n(rst_n), .Valid(Valid), .Addr(Addr), .Data(Data), .Ready(Ready),
    .Frame_end(Frame_end), .Load_config(Load_config), .Pending(Pending), .Cfg_error(Cfg_error),
    .Preset_id(Preset_id), .H_count_max(H_count_max), .V_count_max(V_count_max),
    .H_sync_pulse(H_sync_pulse), .V_sync_pulse(V_sync_pulse),
    .H_left_margin(H_left_margin), .H_right_margin(H_right_margin),
    .V_left_margin(V_left_margin), .V_right_margin(V_right_margin));

  vga_timing_cfg_bank #(.TIMEOUT_WIDTH(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .Valid(wd_valid), .Addr(Addr), .Data(Data), .Ready(w_ready),
    .Frame_end(Frame_end), .Load_config(w_load), .Pending(w_pending), .Cfg_error(w_error),
    .Preset_id(w_preset), .H_count_max(w_hmax), .V_count_max(w_vmax),
    .H_sync_pulse(w_hsync), .V_sync_pulse(w_vsync),
    .H_left_margin(w_hl), .H_right_margin(w_hr), .V_left_margin(w_vl), .V_right_margin(w_vr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] a, input logic [15:0] d);
    Valid = 1'b1; Addr = a; Data = d;
    tick();
    Valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    if (Load_config !== 1'b1) begin $display("FAIL reset_load_in_reset got=%b exp=1", Load_config); miscompares++; end vectors++;
    rst_n = 1'b1;
    if (Load_config !== 1'b1) begin $display("FAIL reset_load_released got=%b exp=1", Load_config); miscompares++; end vectors++;
    if (act !== P0) begin $display("FAIL reset_active got=%h exp=%h", act, P0); miscompares++; end vectors++;
    if (Preset_id !== 2'd0) begin $display("FAIL reset_preset got=%0d exp=0", Preset_id); miscompares++; end vectors++;
    if ({Ready, Pending, Cfg_error} !== 3'b100) begin $display("FAIL reset_flags got=%b exp=100", {Ready, Pending, Cfg_error}); miscompares++; end vectors++;
    tick();
    if (Load_config !== 1'b0) begin $display("FAIL reset_load_drop got=%b exp=0", Load_config); miscompares++; end vectors++;
    if (act !== P0) begin $display("FAIL reset_active_hold got=%h exp=%h", act, P0); miscompares++; end vectors++;
  endtask

  task automatic test_preset_frame();
    write(16'h0010, 16'd2);
    if ({Ready, Pending} !== 2'b00) begin $display("FAIL preset_check_flags got=%b exp=00", {Ready, Pending}); miscompares++; end vectors++;
    tick();
    for (int i = 0; i < 50; i++) begin
      if ({Ready, Pending, Load_config} !== 3'b010) begin $display("FAIL preset_pending_flags cyc=%0d got=%b exp=010", i, {Ready, Pending, Load_config}); miscompares++; end vectors++;
      if (act !== P0) begin $display("FAIL preset_pending_active cyc=%0d got=%h exp=%h", i, act, P0); miscompares++; end vectors++;
      if (i == 49) Frame_end = 1'b1;
      tick();
    end
    Frame_end = 1'b0;
    if (Load_config !== 1'b1) begin $display("FAIL preset_apply_load got=%b exp=1", Load_config); miscompares++; end vectors++;
    if (act !== P2) begin $display("FAIL preset_apply_active got=%h exp=%h", act, P2); miscompares++; end vectors++;
    if (Preset_id !== 2'd2) begin $display("FAIL preset_apply_id got=%0d exp=2", Preset_id); miscompares++; end vectors++;
    if ({Ready, Pending} !== 2'b00) begin $display("FAIL preset_apply_flags got=%b exp=00", {Ready, Pending}); miscompares++; end vectors++;
    tick();
    if ({Ready, Load_config} !== 2'b10) begin $display("FAIL preset_after_flags got=%b exp=10", {Ready, Load_config}); miscompares++; end vectors++;
  endtask

  task automatic test_bad_address();
    logic [15:0] addrs [4] = '{16'h001A, 16'h000F, 16'h0020, 16'h001F};
    logic        errs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      write(addrs[i], 16'd1);
      if ({Cfg_error, Ready} !== {errs[i], 1'b1}) begin $display("FAIL bad_addr_%h got=%b exp=%b", addrs[i], {Cfg_error, Ready}, {errs[i], 1'b1}); miscompares++; end vectors++;
      tick();
      if (Cfg_error !== 1'b0) begin $display("FAIL bad_addr_pulse_%h got=%b exp=0", addrs[i], Cfg_error); miscompares++; end vectors++;
    end
    if (act !== P2 || Pending !== 1'b0) begin $display("FAIL bad_addr_state got=%h/%b exp=%h/0", act, Pending, P2); miscompares++; end vectors++;
  endtask

  task automatic test_custom_commit_now();
    logic [15:0] vals [8] = '{16'd999, 16'd599, 16'd100, 16'd5, 16'd50, 16'd50, 16'd20, 16'd5};
    for (int i = 0; i < 8; i++) write(16'h0011 + 16'(i), vals[i]);
    if ({Ready, Load_config} !== 2'b10) begin $display("FAIL custom_fields_flags got=%b exp=10", {Ready, Load_config}); miscompares++; end vectors++;
    if (act !== P2) begin $display("FAIL custom_fields_active got=%h exp=%h", act, P2); miscompares++; end vectors++;
    Frame_end = 1'b1;
    tick();
    Frame_end = 1'b0;
    if (Load_config !== 1'b0 || act !== P2) begin $display("FAIL idle_frame_end got=%b/%h exp=0/%h", Load_config, act, P2); miscompares++; end vectors++;
    write(16'h0019, 16'd0);
    if ({Ready, Load_config} !== 2'b00) begin $display("FAIL now_check_flags got=%b exp=00", {Ready, Load_config}); miscompares++; end vectors++;
    tick();
    if (Load_config !== 1'b1) begin $display("FAIL now_load got=%b exp=1", Load_config); miscompares++; end vectors++;
    if (act !== CUST) begin $display("FAIL now_active got=%h exp=%h", act, CUST); miscompares++; end vectors++;
    if (Preset_id !== 2'd3) begin $display("FAIL now_id got=%0d exp=3", Preset_id); miscompares++; end vectors++;
    tick();
    if ({Ready, Load_config} !== 2'b10) begin $display("FAIL now_after_flags got=%b exp=10", {Ready, Load_config}); miscompares++; end vectors++;
  endtask

  task automatic test_bad_timing();
    logic [15:0] hmax [2] = '{16'd100, 16'd200};
    for (int i = 0; i < 2; i++) begin
      write(16'h0011, hmax[i]);
      write(16'h0010, 16'd3);
      if ({Ready, Cfg_error} !== 2'b00) begin $display("FAIL bad_timing_check_%0d got=%b exp=00", hmax[i], {Ready, Cfg_error}); miscompares++; end vectors++;
      tick();
      if ({Cfg_error, Pending, Load_config} !== 3'b100) begin $display("FAIL bad_timing_err_%0d got=%b exp=100", hmax[i], {Cfg_error, Pending, Load_config}); miscompares++; end vectors++;
      if (act !== CUST || Preset_id !== 2'd3) begin $display("FAIL bad_timing_active_%0d got=%h/%0d exp=%h/3", hmax[i], act, Preset_id, CUST); miscompares++; end vectors++;
      tick();
      if ({Ready, Cfg_error} !== 2'b10) begin $display("FAIL bad_timing_after_%0d got=%b exp=10", hmax[i], {Ready, Cfg_error}); miscompares++; end vectors++;
    end
    write(16'h0011, 16'd201);
    write(16'h0010, 16'd3);
    tick();
    if ({Pending, Cfg_error} !== 2'b10) begin $display("FAIL edge_timing_pending got=%b exp=10", {Pending, Cfg_error}); miscompares++; end vectors++;
    Frame_end = 1'b1;
    tick();
    Frame_end = 1'b0;
    if (Load_config !== 1'b1 || act !== C201) begin $display("FAIL edge_timing_apply got=%b/%h exp=1/%h", Load_config, act, C201); miscompares++; end vectors++;
    tick();
  endtask

  task automatic test_back_to_back();
    Valid = 1'b1; Addr = 16'h0010; Data = 16'd1;
    tick();
    if (Ready !== 1'b0) begin $display("FAIL b2b_check_ready got=%b exp=0", Ready); miscompares++; end vectors++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({Ready, Pending} !== 2'b01) begin $display("FAIL b2b_hold cyc=%0d got=%b exp=01", i, {Ready, Pending}); miscompares++; end vectors++;
    end
    Frame_end = 1'b1;
    tick();
    Frame_end = 1'b0;
    if ({Load_config, Ready} !== 2'b10 || act !== P1 || Preset_id !== 2'd1) begin $display("FAIL b2b_first_apply got=%b/%h/%0d exp=10/%h/1", {Load_config, Ready}, act, Preset_id, P1); miscompares++; end vectors++;
    tick();
    if ({Ready, Load_config, Pending} !== 3'b100) begin $display("FAIL b2b_idle got=%b exp=100", {Ready, Load_config, Pending}); miscompares++; end vectors++;
    tick();
    Valid = 1'b0;
    Frame_end = 1'b1;
    if ({Ready, Pending} !== 2'b00) begin $display("FAIL b2b_second_check got=%b exp=00", {Ready, Pending}); miscompares++; end vectors++;
    tick();
    Frame_end = 1'b0;
    if ({Pending, Load_config} !== 2'b10) begin $display("FAIL b2b_check_frame_missed got=%b exp=10", {Pending, Load_config}); miscompares++; end vectors++;
    tick();
    tick();
    if ({Pending, Load_config} !== 2'b10) begin $display("FAIL b2b_second_pending got=%b exp=10", {Pending, Load_config}); miscompares++; end vectors++;
    Frame_end = 1'b1;
    tick();
    Frame_end = 1'b0;
    if (Load_config !== 1'b1 || act !== P1 || Preset_id !== 2'd1) begin $display("FAIL b2b_second_apply got=%b/%h/%0d exp=1/%h/1", Load_config, act, Preset_id, P1); miscompares++; end vectors++;
    tick();
    if ({Ready, Load_config} !== 2'b10) begin $display("FAIL b2b_done got=%b exp=10", {Ready, Load_config}); miscompares++; end vectors++;
  endtask

  task automatic test_watchdog();
    wd_valid = 1'b1; Addr = 16'h0010; Data = 16'd1;
    tick();
    wd_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if ({w_pending, w_load} !== 2'b10) begin $display("FAIL wd_pending cyc=%0d got=%b exp=10", i, {w_pending, w_load}); miscompares++; end vectors++;
    end
    tick();
    if ({w_load, w_pending} !== 2'b10) begin $display("FAIL wd_forced_load got=%b exp=10", {w_load, w_pending}); miscompares++; end vectors++;
    if (w_act !== P1 || w_preset !== 2'd1) begin $display("FAIL wd_forced_active got=%h/%0d exp=%h/1", w_act, w_preset, P1); miscompares++; end vectors++;
    tick();
    if ({w_ready, w_load, w_error} !== 3'b100) begin $display("FAIL wd_after got=%b exp=100", {w_ready, w_load, w_error}); miscompares++; end vectors++;
  endtask

  task automatic test_reset_mid_pending();
    write(16'h0010, 16'd2);
    tick();
    if (Pending !== 1'b1) begin $display("FAIL rst_mid_armed got=%b exp=1", Pending); miscompares++; end vectors++;
    #2 rst_n = 1'b0;
    #1;
    if ({Pending, Load_config, Ready} !== 3'b011 || act !== P0 || Preset_id !== 2'd0) begin $display("FAIL rst_mid_state got=%b/%h/%0d exp=011/%h/0", {Pending, Load_config, Ready}, act, Preset_id, P0); miscompares++; end vectors++;
    tick();
    rst_n = 1'b1;
    tick();
    Frame_end = 1'b1;
    tick();
    Frame_end = 1'b0;
    if ({Load_config, Pending} !== 2'b00 || act !== P0) begin $display("FAIL rst_mid_discarded got=%b/%h exp=00/%h", {Load_config, Pending}, act, P0); miscompares++; end vectors++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; Valid = 1'b0; wd_valid = 1'b0; Addr = '0; Data = '0; Frame_end = 1'b0;
    test_reset();
    test_preset_frame();
    test_bad_address();
    test_custom_commit_now();
    test_bad_timing();
    test_back_to_back();
    test_watchdog();
    test_reset_mid_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
